// File: rtl/frame_pkg.sv
// Shared definitions for the frame generator: FSM state encoding and the
// default framing words used when the top-level parameters are left alone.
package frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COMMA   = 3'd1,
        ST_HEAD    = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_TAIL    = 3'd4,
        ST_GAP     = 3'd5
    } frame_state_e;

    localparam logic [15:0] COMMA_WORD_DEF = 16'h017C;
    localparam logic [15:0] HEAD_WORD_DEF  = 16'h5555;
    localparam logic [15:0] TAIL_WORD_DEF  = 16'hAAAA;

    function automatic logic is_beat_state(input frame_state_e s);
        return (s == ST_COMMA) || (s == ST_HEAD) || (s == ST_PAYLOAD) || (s == ST_TAIL);
    endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// Fibonacci PRBS generator producing NBITS fresh bits per step; the first
// generated bit of a step lands in the MSB of data_out.
module prbs_lfsr #(
    parameter int POLY_LEN    = 9,
    parameter int POLY_TAP    = 5,
    parameter int INV_PATTERN = 1,
    parameter int NBITS       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic             en,
    output logic [NBITS-1:0] data_out
);

    logic [POLY_LEN-1:0] lfsr_q;
    logic [POLY_LEN-1:0] lfsr_d;
    logic [NBITS-1:0]    word_s;

    function automatic logic [POLY_LEN+NBITS-1:0] lfsr_steps(input logic [POLY_LEN-1:0] state);
        logic [POLY_LEN-1:0] s;
        logic [NBITS-1:0]    w;
        logic                fb;
        s  = state;
        w  = '0;
        fb = 1'b0;
        for (int i = 0; i < NBITS; i++) begin
            fb = s[POLY_LEN-1] ^ s[POLY_TAP-1];
            w  = {w[NBITS-2:0], fb};
            s  = {s[POLY_LEN-2:0], fb};
        end
        return {s, w};
    endfunction

    // The current word and the post-step state come from the same unrolled shift.
    always_comb begin
        {lfsr_d, word_s} = lfsr_steps(lfsr_q);
    end

    // LFSR register: reseeded to all-ones, advanced one word per enabled cycle.
    always_ff @(posedge clk) begin
        if (rst || seed_load) begin
            lfsr_q <= '1;
        end else if (en) begin
            lfsr_q <= lfsr_d;
        end else begin
            lfsr_q <= lfsr_q;
        end
    end

    assign data_out = (INV_PATTERN != 0) ? ~word_s : word_s;

endmodule

// File: rtl/frame_gen.sv
// Framed test-pattern source: comma, header, PRBS payload and tail beats over a
// valid/ready link, with an idle gap between frames and a back-to-back mode.
module frame_gen
    import frame_pkg::*;
#(
    parameter int          DATA_W      = 16,
    parameter int          PAYLOAD_MAX = 32,
    parameter int          POLY_LEN    = 9,
    parameter int          POLY_TAP    = 5,
    parameter int          INV_PATTERN = 1,
    parameter int          GAP_CYCLES  = 4,
    parameter logic [15:0] COMMA_WORD  = COMMA_WORD_DEF,
    parameter logic [15:0] HEAD_WORD   = HEAD_WORD_DEF,
    parameter logic [15:0] TAIL_WORD   = TAIL_WORD_DEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               continuous,
    input  logic [$clog2(PAYLOAD_MAX+1)-1:0]   payload_len,
    output logic                               tx_valid,
    input  logic                               tx_ready,
    output logic [DATA_W-1:0]                  tx_data,
    output logic                               tx_sof,
    output logic                               tx_eof,
    output logic                               busy,
    output logic [15:0]                        frame_cnt,
    output logic                               len_err
);

    localparam int                LW       = $clog2(PAYLOAD_MAX + 1);
    localparam int                GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0]     GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [LW-1:0]     LEN_MAX  = LW'(PAYLOAD_MAX);
    localparam logic [DATA_W-1:0] COMMA_W  = DATA_W'(COMMA_WORD);
    localparam logic [DATA_W-1:0] HEAD_W   = DATA_W'(HEAD_WORD);
    localparam logic [DATA_W-1:0] TAIL_W   = DATA_W'(TAIL_WORD);

    frame_state_e      state_q, state_d;
    logic [LW-1:0]     len_q, len_d;
    logic [LW-1:0]     pay_cnt_q, pay_cnt_d;
    logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              len_err_q, len_err_d;

    logic              accept_s;
    logic              launch_s;
    logic              seed_s;
    logic              lfsr_en_s;
    logic              valid_s;
    logic              sof_s;
    logic              eof_s;
    logic [DATA_W-1:0] data_s;
    logic [DATA_W-1:0] prbs_word_s;

    prbs_lfsr #(
        .POLY_LEN    (POLY_LEN),
        .POLY_TAP    (POLY_TAP),
        .INV_PATTERN (INV_PATTERN),
        .NBITS       (DATA_W)
    ) u_prbs (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_s),
        .en        (lfsr_en_s),
        .data_out  (prbs_word_s)
    );

    assign accept_s = valid_s & tx_ready;

    // Next-state logic; every launch path funnels through launch_s so the
    // length latch, clamp and reseed happen identically from IDLE, GAP or TAIL.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        pay_cnt_d   = pay_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        frame_cnt_d = frame_cnt_q;
        len_err_d   = 1'b0;
        launch_s    = 1'b0;
        seed_s      = 1'b0;
        lfsr_en_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start || continuous) begin
                    launch_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMMA: begin
                if (accept_s) begin
                    state_d = ST_HEAD;
                end else begin
                    state_d = ST_COMMA;
                end
            end
            ST_HEAD: begin
                if (accept_s) begin
                    pay_cnt_d = '0;
                    state_d   = (len_q != '0) ? ST_PAYLOAD : ST_TAIL;
                end else begin
                    state_d = ST_HEAD;
                end
            end
            ST_PAYLOAD: begin
                if (accept_s) begin
                    lfsr_en_s = 1'b1;
                    if (pay_cnt_q == (len_q - LW'(1))) begin
                        state_d = ST_TAIL;
                    end else begin
                        pay_cnt_d = pay_cnt_q + LW'(1);
                    end
                end else begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_TAIL: begin
                if (accept_s) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    if (GAP_CYCLES > 0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = '0;
                    end else if (continuous) begin
                        launch_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_TAIL;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    if (continuous) begin
                        launch_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (launch_s) begin
            state_d   = ST_COMMA;
            seed_s    = 1'b1;
            len_err_d = (payload_len > LEN_MAX);
            len_d     = (payload_len > LEN_MAX) ? LEN_MAX : payload_len;
        end else begin
            seed_s = 1'b0;
        end
    end

    // Beat decode from the state register only, so nothing moves during a stall.
    always_comb begin
        valid_s = is_beat_state(state_q);
        sof_s   = 1'b0;
        eof_s   = 1'b0;
        data_s  = '0;
        case (state_q)
            ST_COMMA: begin
                sof_s  = 1'b1;
                data_s = COMMA_W;
            end
            ST_HEAD:    data_s = HEAD_W;
            ST_PAYLOAD: data_s = prbs_word_s;
            ST_TAIL: begin
                eof_s  = 1'b1;
                data_s = TAIL_W;
            end
            default: begin
                data_s = '0;
            end
        endcase
    end

    // State and counters; rst aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            pay_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            frame_cnt_q <= 16'd0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            pay_cnt_q   <= pay_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            len_err_q   <= len_err_d;
        end
    end

    assign tx_valid  = valid_s;
    assign tx_data   = data_s;
    assign tx_sof    = sof_s;
    assign tx_eof    = eof_s;
    assign busy      = (state_q != ST_IDLE);
    assign frame_cnt = frame_cnt_q;
    assign len_err   = len_err_q;

endmodule

// File: tb/tb_frame_gen.sv
// Scoreboard bench for frame_gen: directed frames push expected beats, a
// negedge monitor pops and compares every accepted beat.
`timescale 1ns/1ps
module tb_frame_gen;

    localparam int LW = 6;
    localparam int PMAX = 32;

    logic          clk = 1'b0;
    logic          rst, start, continuous, tx_ready;
    logic [LW-1:0] payload_len;
    logic          tx_valid, tx_sof, tx_eof, busy, len_err;
    logic [15:0]   tx_data, frame_cnt;

    always #5 clk = ~clk;

    frame_gen #(
        .DATA_W(16), .PAYLOAD_MAX(PMAX), .POLY_LEN(9), .POLY_TAP(5),
        .INV_PATTERN(1), .GAP_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous),
        .payload_len(payload_len), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_data(tx_data), .tx_sof(tx_sof), .tx_eof(tx_eof), .busy(busy),
        .frame_cnt(frame_cnt), .len_err(len_err)
    );

    typedef struct packed {
        logic [15:0] data;
        logic        sof;
        logic        eof;
    } beat_t;

    beat_t       exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          ready_mode = 0;
    logic [15:0] prbs_w [0:PMAX-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected payload from the bit recurrence y[n] = y[n-9] ^ y[n-5], all-ones history.
    task automatic build_prbs();
        bit seq [0:9+PMAX*16-1];
        logic [15:0] w;
        for (int i = 0; i < 9; i++) seq[i] = 1'b1;
        for (int n = 9; n < 9 + PMAX * 16; n++) seq[n] = seq[n-9] ^ seq[n-5];
        for (int k = 0; k < PMAX; k++) begin
            w = '0;
            for (int b = 0; b < 16; b++) w[15-b] = seq[9 + 16 * k + b];
            prbs_w[k] = ~w;
        end
    endtask

    function automatic beat_t mk(input logic [15:0] d, input logic s, input logic e);
        beat_t b;
        b.data = d;
        b.sof  = s;
        b.eof  = e;
        return b;
    endfunction

    task automatic push_partial(input int n);
        exp_q.push_back(mk(16'h017C, 1'b1, 1'b0));
        exp_q.push_back(mk(16'h5555, 1'b0, 1'b0));
        for (int k = 0; k < n; k++) exp_q.push_back(mk(prbs_w[k], 1'b0, 1'b0));
    endtask

    task automatic push_frame(input int n);
        push_partial(n);
        exp_q.push_back(mk(16'hAAAA, 1'b0, 1'b1));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [LW-1:0] len);
        start = 1'b1;
        payload_len = len;
        tick();
        start = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        check({name, "_drain"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Called in the first cycle after the tail handshake.
    task automatic gap_check(input string name);
        for (int i = 0; i < 4; i++) begin
            check({name, "_gap"}, {busy, tx_valid}, 2'b10);
            tick();
        end
        check({name, "_idle_after_gap"}, busy, 1'b0);
    endtask

    // Ready driver: constant 1, or toggling every cycle.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1) tx_ready = ~tx_ready;
            else tx_ready = 1'b1;
        end
    end

    // Monitor: pops on every accepted beat and checks stall stability.
    logic  stall_q = 1'b0;
    beat_t held_q;
    beat_t mon_e;
    always @(negedge clk) begin
        if (stall_q) begin
            check("stall_hold", {tx_valid, tx_data, tx_sof, tx_eof}, {1'b1, held_q});
        end
        if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                tests = tests + 1;
                fails = fails + 1;
                $display("FAIL unexpected_beat: got data %h, expected no beat", tx_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("beat_data", tx_data, mon_e.data);
                check("beat_sof_eof", {tx_sof, tx_eof}, {mon_e.sof, mon_e.eof});
            end
        end else if (!tx_valid) begin
            check("idle_flags", {tx_sof, tx_eof}, 2'b00);
        end
        stall_q <= tx_valid && !tx_ready;
        held_q  <= mk(tx_data, tx_sof, tx_eof);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    int sofs, gap_len, k, start_at;

    initial begin
        rst = 1'b1; start = 1'b0; continuous = 1'b0; payload_len = '0;
        build_prbs();
        repeat (3) tick();
        check("rst_outputs", {tx_valid, tx_sof, tx_eof, busy, len_err}, 5'b0);
        check("rst_data", tx_data, 16'h0000);
        check("rst_frame_cnt", frame_cnt, 16'h0000);
        rst = 1'b0;
        tick();
        check("post_rst_outputs", {tx_valid, busy, len_err, tx_data}, 19'h0);

        // Nominal frame, length change after launch must not matter.
        push_frame(8);
        launch(6'd8);
        check("t1_len_err", len_err, 1'b0);
        check("t1_busy", busy, 1'b1);
        payload_len = 6'd3;
        drain("t1");
        check("t1_frame_cnt", frame_cnt, 16'd1);
        gap_check("t1");

        // Backpressure every other cycle.
        ready_mode = 1;
        push_frame(8);
        launch(6'd8);
        drain("t2");
        ready_mode = 0;
        check("t2_frame_cnt", frame_cnt, 16'd2);
        gap_check("t2");

        // Empty payload.
        push_frame(0);
        launch(6'd0);
        check("t3_len_err", len_err, 1'b0);
        drain("t3");
        check("t3_frame_cnt", frame_cnt, 16'd3);
        gap_check("t3");

        // Oversized request is clamped.
        push_frame(32);
        launch(6'd40);
        check("t4_len_err_pulse", len_err, 1'b1);
        tick();
        check("t4_len_err_drop", len_err, 1'b0);
        drain("t4");
        check("t4_frame_cnt", frame_cnt, 16'd4);
        gap_check("t4");

        // Continuous mode, three frames, stray start pulses.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_cnt_cleared", frame_cnt, 16'd0);
        for (int f = 0; f < 3; f++) push_frame(2);
        continuous = 1'b1;
        payload_len = 6'd2;
        sofs = 0; gap_len = 0; k = 0; start_at = -1;
        while (k < 300 && !(sofs == 3 && exp_q.size() == 0)) begin
            tick();
            k++;
            if (tx_valid && tx_sof) begin
                sofs++;
                if (sofs > 1) check("t5_gap_len", gap_len, 4);
                gap_len = 0;
                if (sofs == 3) begin
                    continuous = 1'b0;
                    start_at = k + 2;
                end
            end else if (busy && !tx_valid) begin
                gap_len++;
            end
            start = (k == start_at) || (k == 3);
        end
        start = 1'b0;
        check("t5_sof_count", sofs, 3);
        drain("t5");
        check("t5_frame_cnt", frame_cnt, 16'd3);
        gap_check("t5");
        repeat (3) tick();
        check("t5_no_queued_start", busy, 1'b0);

        // Reset while payload beat 3 is on the bus.
        push_partial(4);
        launch(6'd8);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_abort_valid_busy", {tx_valid, busy}, 2'b00);
        check("t6_abort_cnt", frame_cnt, 16'd0);
        check("t6_abort_data", tx_data, 16'h0000);
        check("t6_beats_seen", exp_q.size(), 0);
        exp_q.delete();
        push_frame(8);
        launch(6'd8);
        drain("t6");
        check("t6_frame_cnt", frame_cnt, 16'd1);
        gap_check("t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
